if_fetch_queue: RTL and testbench

//  Instruction-fetch front end that feeds the decode stage. Owns the fetch PC, runs a
//  req/ack handshake to instruction memory, and buffers fetched words in a small queue.

---
 rtl/if_fetch_queue.sv | 175 +++++++++++++++++
 tb/tb_if_fetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, runs the IMem req/ack handshake and
// buffers fetched words in a small queue ahead of the decode stage.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC    = 32'h0040_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Request_Alt_PC,
    input  logic [31:0] Alt_PC,
    input  logic        WANT_FREEZE,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic        Instr_Valid_OUT
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      target_q, target_d;
    logic [31:0]      q_pc_q [QUEUE_DEPTH];
    logic [31:0]      q_pc_d [QUEUE_DEPTH];
    logic [31:0]      q_data_q [QUEUE_DEPTH];
    logic [31:0]      q_data_d [QUEUE_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_out_q, pc_out_d;
    logic [31:0]      pc4_out_q, pc4_out_d;
    logic             valid_q, valid_d;
    logic             xfer, take, bypass, push, pop;

    assign IMem_Req           = (state_q == REQ) || (state_q == DROP);
    assign IMem_Addr          = fetch_pc_q;
    assign Instr1_OUT         = instr_q;
    assign Instr_PC_OUT       = pc_out_q;
    assign Instr_PC_Plus4_OUT = pc4_out_q;
    assign Instr_Valid_OUT    = valid_q;

    // A word is kept only when it was fetched in REQ and no redirect lands on the same edge.
    always_comb begin
        xfer      = IMem_Req && IMem_Ack;
        take      = xfer && (state_q == REQ) && !Request_Alt_PC;
        pop       = !WANT_FREEZE && !Request_Alt_PC && (count_q != '0);
        bypass    = take && !WANT_FREEZE && (count_q == '0);
        push      = take && !bypass;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        pc4_out_d = pc4_out_q;
        valid_d   = valid_q;
        q_pc_d    = q_pc_q;
        q_data_d  = q_data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (!WANT_FREEZE) begin
            if (pop) begin
                instr_d   = q_data_q[head_q];
                pc_out_d  = q_pc_q[head_q];
                pc4_out_d = q_pc_q[head_q] + 32'd4;
                valid_d   = 1'b1;
            end else if (bypass) begin
                instr_d   = IMem_Data;
                pc_out_d  = fetch_pc_q;
                pc4_out_d = fetch_pc_q + 32'd4;
                valid_d   = 1'b1;
            end else begin
                instr_d   = '0;
                valid_d   = 1'b0;
            end
        end

        if (Request_Alt_PC) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                q_pc_d[tail_q]   = fetch_pc_q;
                q_data_d[tail_q] = IMem_Data;
                tail_d           = tail_q + PTR_ONE;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // In DROP the stale address stays on IMem_Addr; the redirect target waits in target_q.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        case (state_q)
            IDLE: begin
                if (Request_Alt_PC) begin
                    fetch_pc_d = Alt_PC;
                    state_d    = REQ;
                end else if (count_d < DEPTH_C) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (Request_Alt_PC) begin
                    if (xfer) begin
                        fetch_pc_d = Alt_PC;
                    end else begin
                        target_d = Alt_PC;
                        state_d  = DROP;
                    end
                end else if (xfer) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (count_d >= DEPTH_C) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (xfer) begin
                    fetch_pc_d = Request_Alt_PC ? Alt_PC : target_q;
                    state_d    = REQ;
                end else if (Request_Alt_PC) begin
                    target_d = Alt_PC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
            q_pc_q     <= '{default: '0};
            q_data_q   <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            instr_q    <= '0;
            pc_out_q   <= '0;
            pc4_out_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            q_pc_q     <= q_pc_d;
            q_data_q   <= q_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc4_out_q  <= pc4_out_d;
            valid_q    <= valid_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed phases plus a randomized stretch, all checked
// against a queue-based reference model of the fetch front end.
module tb_if_fetch_queue;
    localparam logic [31:0] RESET_PC    = 32'h0040_0000;
    localparam int          QUEUE_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic        clock, reset, requestAltPc, wantFreeze, imemAck;
    logic        imemReq, instrValid;
    logic [31:0] altPc, imemAddr, imemData, instr, instrPc, instrPc4;

    int testCount = 0;
    int failCount = 0;

    bit          mKnown = 0;
    bit          mReq, mDropping, mValid;
    logic [31:0] mAddr, mTarget, mInstr, mPc, mPc4;
    entry_t      mq[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    assign imemData = memWord(imemAddr);

    if_fetch_queue #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(QUEUE_DEPTH)) dut (
        .CLK(clock),
        .RESET(reset),
        .Request_Alt_PC(requestAltPc),
        .Alt_PC(altPc),
        .WANT_FREEZE(wantFreeze),
        .IMem_Req(imemReq),
        .IMem_Addr(imemAddr),
        .IMem_Ack(imemAck),
        .IMem_Data(imemData),
        .Instr1_OUT(instr),
        .Instr_PC_OUT(instrPc),
        .Instr_PC_Plus4_OUT(instrPc4),
        .Instr_Valid_OUT(instrValid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkEq("req",   32'(imemReq),    32'(mReq));
        checkEq("addr",  imemAddr,        mAddr);
        checkEq("instr", instr,           mInstr);
        checkEq("pc",    instrPc,         mPc);
        checkEq("pc4",   instrPc4,        mPc4);
        checkEq("valid", 32'(instrValid), 32'(mValid));
    endtask

    // Reference model: one call per rising edge, using the inputs held during that cycle.
    task automatic modelStep();
        entry_t e;
        bit     xfer, gotWord;
        if (reset) begin
            mKnown = 1; mReq = 0; mDropping = 0;
            mAddr = RESET_PC; mTarget = RESET_PC;
            mq.delete();
            mInstr = 0; mPc = 0; mPc4 = 0; mValid = 0;
            return;
        end
        xfer    = mReq && imemAck;
        gotWord = xfer && !mDropping && !requestAltPc;
        if (!wantFreeze) begin
            if (!requestAltPc && mq.size() > 0) begin
                e = mq.pop_front();
                mInstr = e.data; mPc = e.pc; mPc4 = e.pc + 32'd4; mValid = 1;
            end else if (gotWord && mq.size() == 0) begin
                mInstr = memWord(mAddr); mPc = mAddr; mPc4 = mAddr + 32'd4; mValid = 1;
                gotWord = 0;
            end else begin
                mInstr = 0; mValid = 0;
            end
        end
        if (requestAltPc) mq.delete();
        else if (gotWord) mq.push_back({mAddr, memWord(mAddr)});

        if (!mReq) begin
            if (requestAltPc) begin
                mAddr = altPc; mReq = 1;
            end else if (mq.size() < QUEUE_DEPTH) begin
                mReq = 1;
            end
        end else if (mDropping) begin
            if (xfer) begin
                mAddr = requestAltPc ? altPc : mTarget;
                mDropping = 0;
            end else if (requestAltPc) begin
                mTarget = altPc;
            end
        end else begin
            if (requestAltPc) begin
                if (xfer) mAddr = altPc;
                else begin mDropping = 1; mTarget = altPc; end
            end else if (xfer) begin
                mAddr = mAddr + 32'd4;
                mReq  = (mq.size() < QUEUE_DEPTH);
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit ack, input bit frz, input bit redir,
                                 input logic [31:0] alt);
        @(negedge clock);
        reset = rst; imemAck = ack; wantFreeze = frz; requestAltPc = redir; altPc = alt;
        if (mKnown) checkOutput();
        @(posedge clock);
        modelStep();
    endtask

    initial begin
        bit found;
        reset = 1; imemAck = 0; wantFreeze = 0; requestAltPc = 0; altPc = 0;

        // Zero-wait memory from reset
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        #1;
        checkEq("first_valid", 32'(instrValid), 32'd1);
        checkEq("first_pc", instrPc, RESET_PC);
        checkEq("first_pc4", instrPc4, RESET_PC + 32'd4);
        checkEq("first_instr", instr, memWord(RESET_PC));
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 0);

        // Slow memory: ack every fourth cycle
        for (int i = 0; i < 16; i++) applyStimulus(0, (i % 4) == 3, 0, 0, 0);

        // Freeze until the queue fills, then release
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 0);
        #1 checkEq("freeze_req_drop", 32'(imemReq), 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0);

        // Redirect while a request is pending
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h0040_0100);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            #1 found = instrValid;
        end
        checkEq("redir_found", 32'(found), 32'd1);
        checkEq("redir_pc", instrPc, 32'h0040_0100);

        // Redirect on an ack edge, then a second redirect while dropping
        applyStimulus(0, 1, 0, 1, 32'h0040_0200);
        #1 checkEq("same_edge_addr", imemAddr, 32'h0040_0200);
        applyStimulus(0, 0, 0, 1, 32'h0040_0300);
        applyStimulus(0, 0, 0, 1, 32'h0040_0400);
        #1 checkEq("drop_addr_held", imemAddr, 32'h0040_0200);
        applyStimulus(0, 1, 0, 0, 0);
        #1 checkEq("drop_target", imemAddr, 32'h0040_0400);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0);

        // Address wrap at the top of the space
        applyStimulus(0, 1, 0, 1, 32'hFFFF_FFF8);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        #1 checkEq("wrap_addr", imemAddr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0);

        // Reset in the middle of a wait, then a late ack
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        #1;
        checkEq("rst_req", 32'(imemReq), 32'd0);
        checkEq("rst_addr", imemAddr, RESET_PC);
        checkEq("rst_valid", 32'(instrValid), 32'd0);
        applyStimulus(0, 1, 0, 0, 0);
        #1;
        checkEq("late_ack_addr", imemAddr, RESET_PC);
        checkEq("late_ack_valid", 32'(instrValid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 11) == 0,
                          32'h0040_0000 + (32'($urandom_range(0, 1023)) << 2));
        end
        applyStimulus(0, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
